// File: rtl/l2_arb_types.sv
// Shared types for the L2 port arbiter: FSM state encoding and requester id.
// Latency: none (type definitions only).
// Backpressure: not applicable.
package l2_arb_types;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY_I  = 2'd1,
    ST_BUSY_D  = 2'd2,
    ST_RELEASE = 2'd3
  } arb_state_t;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_id_t;

endpackage

// File: rtl/l2_arbiter_rr_picker.sv
// Two-way round-robin choice between the I-side and D-side requesters.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is used.
import l2_arb_types::*;

module rr_picker (
  input  logic    req_i,
  input  logic    req_d,
  input  req_id_t last_grant,
  output req_id_t pick
);

  // On a tie, the side that was not served last wins; with no request the
  // result is unused, so I is returned as a harmless default.
  always_comb begin
    pick = REQ_I;
    if (req_i && req_d) begin
      pick = (last_grant == REQ_I) ? REQ_D : REQ_I;
    end else if (req_d) begin
      pick = REQ_D;
    end
  end

endmodule

// File: rtl/l2_arbiter.sv
// Shares one L2 port between the I-side and D-side L1 miss paths, round-robin.
// Latency: grant registered onto l2_* one cycle after IDLE sees a request; responses are combinational.
// Backpressure: a losing or late requester holds its request until its own *_resp pulse.
import l2_arb_types::*;

module l2_arbiter #(
  parameter int s_line = 256,
  parameter int s_addr = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic [s_addr-1:0] i_address,
  output logic [s_line-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [s_addr-1:0] d_address,
  input  logic [s_line-1:0] d_wdata,
  output logic [s_line-1:0] d_rdata,
  output logic              d_resp,
  output logic              l2_read,
  output logic              l2_write,
  output logic [s_addr-1:0] l2_address,
  output logic [s_line-1:0] l2_wdata,
  input  logic [s_line-1:0] l2_rdata,
  input  logic              l2_resp
);

  arb_state_t state, state_nxt;
  req_id_t    last_grant;
  req_id_t    pick;
  logic       req_d;
  logic       grant_en;
  logic       done;

  assign req_d = d_read | d_write;

  rr_picker u_rr_picker (
    .req_i      (i_read),
    .req_d      (req_d),
    .last_grant (last_grant),
    .pick       (pick)
  );

  // Read data is broadcast to both sides; only the resp pulses are steered.
  assign i_rdata = l2_rdata;
  assign d_rdata = l2_rdata;

  // Next-state, grant/complete strobes and response steering. l2_resp outside
  // a BUSY state is a protocol error and is deliberately ignored.
  always_comb begin
    state_nxt = state;
    grant_en  = 1'b0;
    done      = 1'b0;
    i_resp    = 1'b0;
    d_resp    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_read || req_d) begin
          grant_en  = 1'b1;
          state_nxt = (pick == REQ_I) ? ST_BUSY_I : ST_BUSY_D;
        end
      end
      ST_BUSY_I: begin
        if (l2_resp) begin
          done      = 1'b1;
          i_resp    = 1'b1;
          state_nxt = ST_RELEASE;
        end
      end
      ST_BUSY_D: begin
        if (l2_resp) begin
          done      = 1'b1;
          d_resp    = 1'b1;
          state_nxt = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        // One dead cycle so the served L1 can drop its request.
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register and fairness pointer; reset makes I win the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      last_grant <= REQ_D;
    end else begin
      state <= state_nxt;
      if (done) begin
        last_grant <= (state == ST_BUSY_I) ? REQ_I : REQ_D;
      end
    end
  end

  // L2 command registers: loaded on a grant, held while busy, command
  // cleared on completion. Address/data keep their value until the next grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      l2_read    <= 1'b0;
      l2_write   <= 1'b0;
      l2_address <= '0;
      l2_wdata   <= '0;
    end else if (grant_en) begin
      if (pick == REQ_I) begin
        l2_read    <= 1'b1;
        l2_write   <= 1'b0;
        l2_address <= i_address;
        l2_wdata   <= '0;
      end else begin
        l2_read    <= d_read;
        l2_write   <= d_write;
        l2_address <= d_address;
        l2_wdata   <= d_wdata;
      end
    end else if (done) begin
      l2_read  <= 1'b0;
      l2_write <= 1'b0;
    end
  end

  // The D-side must never issue a read and a write-back at once.
  a_d_rw_exclusive: assert property (@(posedge clk) disable iff (!rst_n) !(d_read && d_write));

endmodule

// File: tb/tb_l2_arbiter.sv
// Directed self-checking bench for l2_arbiter.
// Latency: checks one-cycle grant and zero-cycle response paths.
// Backpressure: exercises held requests, ties and spurious responses.
import l2_arb_types::*;

module tb_l2_arbiter;

  localparam int s_line = 256;
  localparam int s_addr = 32;

  logic              clk;
  logic              rst_n;
  logic              i_read;
  logic [s_addr-1:0] i_address;
  logic [s_line-1:0] i_rdata;
  logic              i_resp;
  logic              d_read;
  logic              d_write;
  logic [s_addr-1:0] d_address;
  logic [s_line-1:0] d_wdata;
  logic [s_line-1:0] d_rdata;
  logic              d_resp;
  logic              l2_read;
  logic              l2_write;
  logic [s_addr-1:0] l2_address;
  logic [s_line-1:0] l2_wdata;
  logic [s_line-1:0] l2_rdata;
  logic              l2_resp;

  int vectors;
  int miscompares;

  logic [s_line-1:0] pat_aa;
  logic [s_line-1:0] pat_55;
  logic [s_line-1:0] pat_c3;
  logic [s_line-1:0] zero_line;

  l2_arbiter #(.s_line(s_line), .s_addr(s_addr)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_read     (i_read),
    .i_address  (i_address),
    .i_rdata    (i_rdata),
    .i_resp     (i_resp),
    .d_read     (d_read),
    .d_write    (d_write),
    .d_address  (d_address),
    .d_wdata    (d_wdata),
    .d_rdata    (d_rdata),
    .d_resp     (d_resp),
    .l2_read    (l2_read),
    .l2_write   (l2_write),
    .l2_address (l2_address),
    .l2_wdata   (l2_wdata),
    .l2_rdata   (l2_rdata),
    .l2_resp    (l2_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_addr(input string tag, input logic [s_addr-1:0] obs, input logic [s_addr-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_line(input string tag, input logic [s_line-1:0] obs, input logic [s_line-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_st(input string tag, input arb_state_t obs, input arb_state_t exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %s expected %s", tag, obs.name(), exp.name());
    end
  endtask

  // Advance past the next rising edge; inputs are driven and outputs sampled here.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    pat_aa      = {32{8'hAA}};
    pat_55      = {32{8'h55}};
    pat_c3      = {32{8'hC3}};
    zero_line   = '0;
    rst_n       = 1'b0;
    i_read      = 1'b0;
    i_address   = '0;
    d_read      = 1'b0;
    d_write     = 1'b0;
    d_address   = '0;
    d_wdata     = '0;
    l2_rdata    = '0;
    l2_resp     = 1'b0;

    // ---- reset state
    cyc();
    cyc();
    chk_bit("rst_l2_read", l2_read, 1'b0);
    chk_bit("rst_l2_write", l2_write, 1'b0);
    chk_addr("rst_l2_address", l2_address, 32'h0);
    chk_line("rst_l2_wdata", l2_wdata, zero_line);
    chk_bit("rst_i_resp", i_resp, 1'b0);
    chk_bit("rst_d_resp", d_resp, 1'b0);
    chk_st("rst_state", dut.state, ST_IDLE);
    rst_n = 1'b1;

    // ---- I-side read at 0x40, L2 answers after 5 cycles
    cyc();
    i_read    = 1'b1;
    i_address = 32'h0000_0040;
    cyc();
    chk_bit("t1_l2_read", l2_read, 1'b1);
    chk_bit("t1_l2_write", l2_write, 1'b0);
    chk_addr("t1_l2_address", l2_address, 32'h0000_0040);
    chk_st("t1_state", dut.state, ST_BUSY_I);
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk_bit("t1_wait_i_resp", i_resp, 1'b0);
    end
    cyc();
    l2_rdata = pat_aa;
    l2_resp  = 1'b1;
    #1;
    chk_bit("t1_i_resp", i_resp, 1'b1);
    chk_line("t1_i_rdata", i_rdata, pat_aa);
    chk_bit("t1_d_resp", d_resp, 1'b0);
    cyc();
    l2_resp = 1'b0;
    i_read  = 1'b0;
    #1;
    chk_bit("t1_i_resp_once", i_resp, 1'b0);
    chk_bit("t1_l2_read_clr", l2_read, 1'b0);
    chk_st("t1_release", dut.state, ST_RELEASE);
    cyc();
    chk_st("t1_idle", dut.state, ST_IDLE);
    chk_bit("t1_i_resp_after", i_resp, 1'b0);

    // ---- D-side write-back at 0x80
    d_write   = 1'b1;
    d_address = 32'h0000_0080;
    d_wdata   = pat_55;
    cyc();
    chk_bit("t2_l2_write", l2_write, 1'b1);
    chk_bit("t2_l2_read", l2_read, 1'b0);
    chk_addr("t2_l2_address", l2_address, 32'h0000_0080);
    chk_line("t2_l2_wdata", l2_wdata, pat_55);
    chk_st("t2_state", dut.state, ST_BUSY_D);
    cyc();
    l2_rdata = zero_line;
    l2_resp  = 1'b1;
    #1;
    chk_bit("t2_d_resp", d_resp, 1'b1);
    chk_bit("t2_i_resp", i_resp, 1'b0);
    cyc();
    l2_resp = 1'b0;
    d_write = 1'b0;
    #1;
    chk_bit("t2_l2_write_clr", l2_write, 1'b0);
    cyc();
    chk_st("t2_idle", dut.state, ST_IDLE);

    // ---- spurious l2_resp in IDLE
    l2_resp = 1'b1;
    #1;
    chk_bit("t5_i_resp", i_resp, 1'b0);
    chk_bit("t5_d_resp", d_resp, 1'b0);
    cyc();
    chk_st("t5_state", dut.state, ST_IDLE);
    chk_bit("t5_l2_read", l2_read, 1'b0);
    l2_resp = 1'b0;

    // ---- tie right after reset: I first, D 2 cycles after I's response
    rst_n = 1'b0;
    cyc();
    rst_n     = 1'b1;
    i_read    = 1'b1;
    i_address = 32'h0000_0100;
    d_read    = 1'b1;
    d_address = 32'h0000_0200;
    cyc();
    chk_st("t3_first_tie", dut.state, ST_BUSY_I);
    chk_addr("t3_first_addr", l2_address, 32'h0000_0100);
    cyc();
    l2_rdata = pat_c3;
    l2_resp  = 1'b1;
    #1;
    chk_bit("t3_i_resp", i_resp, 1'b1);
    chk_bit("t3_d_resp_loser", d_resp, 1'b0);
    chk_line("t3_d_rdata_bcast", d_rdata, pat_c3);
    cyc();
    l2_resp = 1'b0;
    i_read  = 1'b0;
    #1;
    chk_st("t4_release", dut.state, ST_RELEASE);
    chk_addr("t4_addr_hold1", l2_address, 32'h0000_0100);
    cyc();
    chk_st("t4_idle", dut.state, ST_IDLE);
    chk_addr("t4_addr_hold2", l2_address, 32'h0000_0100);
    chk_bit("t4_no_grant", l2_read, 1'b0);
    cyc();
    chk_st("t4_d_grant", dut.state, ST_BUSY_D);
    chk_addr("t4_d_addr", l2_address, 32'h0000_0200);
    chk_bit("t4_d_l2_read", l2_read, 1'b1);
    cyc();
    l2_resp = 1'b1;
    #1;
    chk_bit("t4_d_resp", d_resp, 1'b1);
    cyc();
    l2_resp   = 1'b0;
    // both sides raise fresh requests: last served was D, so I wins
    i_read    = 1'b1;
    i_address = 32'h0000_0300;
    d_read    = 1'b1;
    d_address = 32'h0000_0400;
    cyc();
    chk_st("t3_idle2", dut.state, ST_IDLE);
    cyc();
    chk_st("t3_second_tie", dut.state, ST_BUSY_I);
    chk_addr("t3_second_addr", l2_address, 32'h0000_0300);
    cyc();
    l2_resp = 1'b1;
    #1;
    chk_bit("t3_i_resp2", i_resp, 1'b1);
    cyc();
    l2_resp = 1'b0;
    i_read  = 1'b0;
    cyc();
    cyc();
    chk_st("t6_busy_d", dut.state, ST_BUSY_D);
    chk_bit("t6_l2_read", l2_read, 1'b1);

    // ---- reset mid-transaction in BUSY_D
    rst_n   = 1'b0;
    l2_resp = 1'b1;
    #1;
    chk_bit("t6_async_l2_read", l2_read, 1'b0);
    chk_bit("t6_rst_d_resp", d_resp, 1'b0);
    chk_st("t6_rst_state", dut.state, ST_IDLE);
    cyc();
    l2_resp = 1'b0;
    d_read  = 1'b0;
    rst_n   = 1'b1;
    cyc();
    chk_st("t6_after_state", dut.state, ST_IDLE);
    chk_bit("t6_after_d_resp", d_resp, 1'b0);
    chk_bit("t6_after_l2_read", l2_read, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
